char_rom_arbiter: RTL

- Shares the single-port synchronous character ROM inside the character ROM controller between two requesters.
- Requester 0 is the video glyph fetch pipeline. It has priority and takes no backpressure on responses.
- Requester 1 is the AXI4-Lite register readback path. It uses a valid/ready handshake on responses.
- A starvation guard bounds the bus requester's wait time. All accepted reads complete in a fixed 2-cycle pipeline.

---
 rtl/char_rom_pkg.sv | 27 ++
 rtl/char_rom_rsp_hold.sv | 32 +++
 rtl/char_rom_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/char_rom_pkg.sv
// Shared types and widths for the character ROM arbiter and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package char_rom_pkg;

    localparam int CHAR_W = 8;
    localparam int ROW_W  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = CHAR_W + ROW_W;

    // One glyph-row read request; packing order matches the ROM address {char, row}.
    typedef struct packed {
        logic [CHAR_W-1:0] chr;
        logic [ROW_W-1:0]  row;
    } glyph_req_t;

    // Stage-1 pipeline tag: a read is in flight and who owns it.
    typedef struct packed {
        logic valid;
        logic is_bus;
    } rom_tag_t;

    function automatic logic [ADDR_W-1:0] glyph_addr(input glyph_req_t r);
        return {r.chr, r.row};
    endfunction

endpackage

// File: rtl/char_rom_rsp_hold.sv
// One-entry valid/ready hold register for a read response (AXI-style readback).
// Latency: 1 cycle from in_vld to out_vld.
// Backpressure: holds out_dat stable until out_rdy; caller loads only when empty or popping.
//
// Ports: core_clk/arst (async active-high), in_vld/in_dat load side,
//        out_vld/out_rdy/out_dat consumer handshake side.
module char_rom_rsp_hold #(
    parameter int DATA_W = 8
) (
    input  logic              core_clk,
    input  logic              arst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_dat
);

    // A load in the same cycle as a pop wins: the entry stays full with new data.
    always_ff @(posedge core_clk or posedge arst) begin
        if (arst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_vld) begin
            out_vld <= 1'b1;
            out_dat <= in_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/char_rom_arbiter.sv
// Shares one synchronous character ROM between video glyph fetch (priority) and bus readback.
// Latency: 2 cycles from request accept to response for both requesters.
// Backpressure: video takes none; bus response held until b_rsp_ready, bus issue limited to 1 per 2 cycles.
//
// Ports: ACLK/ARESET (async active-high); v_req_* / v_rsp_* video requester;
//        b_req_* / b_rsp_* bus requester with response handshake; b_starved flags the
//        starvation override; rom_en/rom_addr/rom_data drive the ROM (data one cycle after enable).
module char_rom_arbiter
    import char_rom_pkg::*;
#(
    parameter int STARVE_MAX = 15,
    parameter int CNT_W      = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              v_req_valid,
    output logic              v_req_ready,
    input  logic [CHAR_W-1:0] v_char,
    input  logic [ROW_W-1:0]  v_row,
    output logic              v_rsp_valid,
    output logic [DATA_W-1:0] v_rsp_data,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic [CHAR_W-1:0] b_char,
    input  logic [ROW_W-1:0]  b_row,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_data,
    output logic              b_starved,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    rom_tag_t         tag_q;
    glyph_req_t       v_req;
    glyph_req_t       b_req;
    glyph_req_t       sel_req;
    logic             bus_ok;
    logic             force_b;
    logic             grant_v;
    logic             grant_b;
    logic             hold_load;

    assign v_req = '{chr: v_char, row: v_row};
    assign b_req = '{chr: b_char, row: b_row};

    // The bus may only issue when its response has a guaranteed landing spot:
    // nothing of its own in stage 1 and the hold register free by the time it loads.
    assign bus_ok = !(tag_q.valid && tag_q.is_bus) && (!b_rsp_valid || b_rsp_ready);

    // Grants are gated by reset so the combinational ROM/ready outputs read 0 during reset.
    assign force_b = !ARESET && (starve_cnt == STARVE_LIM) && b_req_valid && bus_ok;
    assign grant_v = !ARESET && v_req_valid && !force_b;
    assign grant_b = !ARESET && b_req_valid && bus_ok && (!v_req_valid || force_b);

    assign v_req_ready = grant_v;
    assign b_req_ready = grant_b;
    assign b_starved   = force_b;
    assign rom_en      = grant_v || grant_b;

    always_comb begin
        sel_req = '0;
        if (grant_b) begin
            sel_req = b_req;
        end else if (grant_v) begin
            sel_req = v_req;
        end
    end

    assign rom_addr = glyph_addr(sel_req);

    // Stage 1: remember who owns the read whose data appears next cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tag_q <= '0;
        end else begin
            tag_q <= '{valid: rom_en, is_bus: grant_b};
        end
    end

    // Stage 2, video: single-cycle pulse; data keeps its last value between pulses.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            v_rsp_valid <= 1'b0;
            v_rsp_data  <= '0;
        end else begin
            v_rsp_valid <= tag_q.valid && !tag_q.is_bus;
            if (tag_q.valid && !tag_q.is_bus) begin
                v_rsp_data <= rom_data;
            end
        end
    end

    // Starvation counter: only cycles the bus could have issued but lost to video count.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            starve_cnt <= '0;
        end else if (!b_req_valid || grant_b) begin
            starve_cnt <= '0;
        end else if (bus_ok && grant_v && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Stage 2, bus: response parked until the consumer takes it.
    assign hold_load = tag_q.valid && tag_q.is_bus;

    char_rom_rsp_hold #(
        .DATA_W (DATA_W)
    ) u_rsp_hold (
        .core_clk (ACLK),
        .arst     (ARESET),
        .in_vld   (hold_load),
        .in_dat   (rom_data),
        .out_vld  (b_rsp_valid),
        .out_rdy  (b_rsp_ready),
        .out_dat  (b_rsp_data)
    );

endmodule
